// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the KGP RISC multi-cycle shift sequencer.
// Holds the shift-op encodings, the sequencer state encoding and the
// shift-amount saturation limit used by shift_sequencer and shift_step.
package kgp_shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;  // reserved: operand passes through

    // Any shift amount at or above this behaves as a full-width shift.
    localparam int SHAMT_SAT = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/result bundle between the execute stage and the shift sequencer.
// master: drives start/op/A/shamt and observes busy/done/res.
// slave : the sequencer side.
//   start  command valid, sampled only while busy=0
//   op     2-bit shift op (SLL/SRL/SRA/reserved)
//   A      operand
//   shamt  unsigned 32-bit shift amount
//   busy   command in progress
//   done   one-cycle pulse, res valid
//   res    result, held until the next accepted command
interface shift_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [31:0]      shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    modport master (
        output start, op, A, shamt,
        input  busy, done, res
    );

    modport slave (
        input  start, op, A, shamt,
        output busy, done, res
    );
endinterface

// File: rtl/shift_sequencer_shift_step.sv
// Bounded single-cycle shifter: shifts acc by 0..MAX_STEP positions.
// Built as a log-depth mux tree, one stage per bit of step, so the
// critical path scales with log2(MAX_STEP) rather than the full width.
//   acc     input  WIDTH           value to shift
//   op      input  2               SLL/SRL/SRA; reserved passes acc through
//   step    input  log2(MAX_STEP)+1 shift distance, never above MAX_STEP
//   shifted output WIDTH           shifted value
import kgp_shift_pkg::*;

module shift_step #(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 8,
    parameter int SW       = $clog2(MAX_STEP) + 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    input  logic [SW-1:0]    step,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] stage;

    always_comb begin
        stage = acc;
        // Stage k shifts by 2**k when bit k of step is set.
        for (int k = 0; k < SW; k++) begin
            if (step[k]) begin
                case (op)
                    OP_SLL:  stage = stage << (1 << k);
                    OP_SRL:  stage = stage >> (1 << k);
                    OP_SRA:  stage = $unsigned($signed(stage) >>> (1 << k));
                    default: stage = stage;
                endcase
            end
        end
        shifted = stage;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller for the KGP RISC execute stage.
// Takes one SLL/SRL/SRA command through a start/busy/done handshake and
// performs it at most MAX_STEP bit positions per cycle. The result is held
// in res until the next command is accepted.
//   clk  input  system clock, rising edge
//   rst  input  synchronous active-high reset
//   bus  slave modport of shift_sequencer_if (start/op/A/shamt in,
//        busy/done/res out)
import kgp_shift_pkg::*;

module shift_sequencer #(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);

    localparam int RW = $clog2(SHAMT_SAT + 1);  // remaining-count width (0..32)
    localparam int SW = $clog2(MAX_STEP) + 1;   // per-cycle step width

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [1:0]       op_r, op_nx;
    logic [RW-1:0]    rem, rem_nx;
    logic [WIDTH-1:0] res, res_nx;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] shifted;
    logic [RW-1:0]    n_in;

    // Whole 32-bit amount is compared, so e.g. 257 saturates rather than
    // wrapping to 1.
    function automatic logic [RW-1:0] sat_shamt(input logic [31:0] s);
        if (s >= 32'(SHAMT_SAT)) return RW'(SHAMT_SAT);
        return s[RW-1:0];
    endfunction

    function automatic logic [SW-1:0] step_of(input logic [RW-1:0] r);
        if (r > RW'(MAX_STEP)) return SW'(MAX_STEP);
        return r[SW-1:0];
    endfunction

    assign n_in = sat_shamt(bus.shamt);
    assign step = step_of(rem);

    shift_step #(
        .WIDTH    (WIDTH),
        .MAX_STEP (MAX_STEP),
        .SW       (SW)
    ) u_step (
        .acc     (acc),
        .op      (op_r),
        .step    (step),
        .shifted (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            op_r  <= OP_SLL;
            rem   <= '0;
            res   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            op_r  <= op_nx;
            rem   <= rem_nx;
            res   <= res_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        op_nx    = op_r;
        rem_nx   = rem;
        res_nx   = res;

        case (state)
            S_SHIFT: begin
                acc_nx = shifted;
                rem_nx = rem - RW'(step);
                if (rem == RW'(step)) begin
                    state_nx = S_DONE;
                    res_nx   = shifted;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise,
                // which lets a new command follow done with no bubble.
                state_nx = S_IDLE;
                if (bus.start) begin
                    acc_nx = bus.A;
                    op_nx  = bus.op;
                    rem_nx = n_in;
                    if (n_in == '0 || bus.op == OP_RSV) begin
                        state_nx = S_DONE;
                        res_nx   = bus.A;
                    end else begin
                        state_nx = S_SHIFT;
                    end
                end
            end
        endcase
    end

    assign bus.busy = (state == S_SHIFT);
    assign bus.done = (state == S_DONE);
    assign bus.res  = res;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a latency/result model predicts
// busy, done and res every cycle; directed commands add literal checks of
// result and accept-to-done latency.
import kgp_shift_pkg::*;

module tb_shift_sequencer;

    localparam int MS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_sequencer_if #(.WIDTH(32)) sif ();

    shift_sequencer #(.WIDTH(32), .MAX_STEP(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the shift definitions.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] s);
        int n;
        n = (s >= 32) ? 32 : int'(s);
        case (o)
            OP_SLL:  return (n == 32) ? 32'h0 : a << n;
            OP_SRL:  return (n == 32) ? 32'h0 : a >> n;
            OP_SRA:  return (n == 32) ? {32{a[31]}} : $unsigned($signed(a) >>> n);
            default: return a;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] s);
        int n;
        n = (s >= 32) ? 32 : int'(s);
        if (n == 0 || o == OP_RSV) return 1;
        return 1 + (n + MS - 1) / MS;
    endfunction

    // Model: remaining cycles of the in-flight command plus expected outputs.
    bit          m_ok = 0;
    bit          m_busy, m_done;
    logic [31:0] m_res, m_pend;
    int          m_left;

    always @(posedge clk) begin
        bit accept;
        int lat;
        if (rst) begin
            m_ok = 1; m_busy = 0; m_done = 0; m_res = 0; m_left = 0;
        end else if (m_ok) begin
            accept = sif.start && !m_busy;
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_res = m_pend;
                end
            end
            if (accept) begin
                lat = ref_latency(sif.op, sif.shamt);
                if (lat == 1) begin
                    m_done = 1;
                    m_res  = ref_shift(sif.op, sif.A, sif.shamt);
                end else begin
                    m_busy = 1;
                    m_left = lat - 1;
                    m_pend = ref_shift(sif.op, sif.A, sif.shamt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("busy", {31'b0, sif.busy}, {31'b0, m_busy});
            check("done", {31'b0, sif.done}, {31'b0, m_done});
            check("res",  sif.res, m_res);
        end
    end

    // Called at a negedge; counts edges from the last accept until done.
    task automatic wait_done(input int lat0, output int lat, output bit seen);
        lat  = lat0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (sif.done) seen = 1;
            else begin
                lat++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_cmd(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] s, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit seen;
        sif.start = 1'b1; sif.op = o; sif.A = a; sif.shamt = s;
        @(negedge clk);
        sif.start = 1'b0;
        wait_done(1, lat, seen);
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_res"}, sif.res, exp_res);
    endtask

    initial begin
        int lat;
        bit seen;
        int dcount;

        sif.start = 1'b0; sif.op = OP_SLL; sif.A = '0; sif.shamt = '0;

        // Pin the model to hand-computed values.
        check("model_sra5", ref_shift(OP_SRA, 32'hCCC9CCC9, 32'd5), 32'hFE664E66);
        check("model_lat_sll31", ref_latency(OP_SLL, 32'd31), 32'd5);

        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, sif.busy}, 32'd0);
        check("rst_done", {31'b0, sif.done}, 32'd0);
        check("rst_res",  sif.res, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive commands start in the previous DONE cycle (no bubble).
        run_cmd("sra5",     OP_SRA, 32'hCCC9CCC9, 32'd5,   32'hFE664E66, 2);
        run_cmd("sll31",    OP_SLL, 32'h00000001, 32'd31,  32'h80000000, 5);
        run_cmd("srl40",    OP_SRL, 32'h80000000, 32'd40,  32'h00000000, 5);
        run_cmd("sra40",    OP_SRA, 32'h80000000, 32'd40,  32'hFFFFFFFF, 5);
        run_cmd("srl0",     OP_SRL, 32'h727339C9, 32'd0,   32'h727339C9, 1);
        run_cmd("rsv7",     OP_RSV, 32'h727339C9, 32'd7,   32'h727339C9, 1);
        run_cmd("srl257",   OP_SRL, 32'hFFFFFFFF, 32'd257, 32'h00000000, 5);
        run_cmd("sll8",     OP_SLL, 32'h12345678, 32'd8,   32'h34567800, 2);
        run_cmd("srl16",    OP_SRL, 32'h12345678, 32'd16,  32'h00001234, 3);
        run_cmd("sra32pos", OP_SRA, 32'h7F000000, 32'd32,  32'h00000000, 5);
        @(negedge clk);
        @(negedge clk);

        // start held high into SHIFT with a different command: ignored.
        sif.start = 1'b1; sif.op = OP_SLL; sif.A = 32'h1; sif.shamt = 32'd31;
        @(negedge clk);
        sif.op = OP_SRL; sif.A = 32'hDEADBEEF; sif.shamt = 32'd3;
        @(negedge clk);
        sif.start = 1'b0;
        wait_done(2, lat, seen);
        check("ignore_done_seen", {31'b0, seen}, 32'd1);
        check("ignore_latency", lat, 32'd5);
        check("ignore_res", sif.res, 32'h80000000);
        repeat (2) @(negedge clk);

        // Reset during the second SHIFT cycle abandons the command.
        sif.start = 1'b1; sif.op = OP_SLL; sif.A = 32'h1; sif.shamt = 32'd31;
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        check("midrst_busy_before", {31'b0, sif.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'b0, sif.busy}, 32'd0);
        check("midrst_done", {31'b0, sif.done}, 32'd0);
        check("midrst_res",  sif.res, 32'd0);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sif.done) dcount++;
        end
        check("midrst_no_done", dcount, 32'd0);

        run_cmd("after_rst_sra9", OP_SRA, 32'h80000000, 32'd9, 32'hFFC00000, 3);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
